// File: rtl/spine_switch_fwd.sv
// Spine-side forwarding switch.
// Four leaf-facing inputs, each buffered in its own FIFO. The FIFO head's
// destination group selects one of four downstream outputs; every output runs
// its own round-robin arbiter and drives a registered valid/ready stage.
// Heads carrying GroupID 0 are discarded and reported on drop_err.
module spine_switch_fwd #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          in_valid,
    output logic [3:0]          in_ready,
    input  logic [23:0]         in_dest,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [23:0]         out_dest,
    output logic [4*DATA_W-1:0] out_data,
    output logic [3:0]          drop_err
);

    localparam int NP = 4;
    localparam int AW = $clog2(FIFO_DEPTH);

    // One extra pointer bit tells full from empty once the index bits meet.
    typedef logic [AW:0] ptr_t;

    // Per-input FIFO storage and pointers
    logic [5:0]        mem_dest [NP][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [NP][FIFO_DEPTH];
    ptr_t              wr_ptr   [NP];
    ptr_t              rd_ptr   [NP];

    logic [NP-1:0]     fifo_full;
    logic [NP-1:0]     fifo_empty;
    logic [NP-1:0]     push;
    logic [NP-1:0]     pop;

    // Head-of-FIFO view and its decode
    logic [5:0]        head_dest [NP];
    logic [DATA_W-1:0] head_data [NP];
    logic [NP-1:0]     head_inv;
    logic [1:0]        head_out  [NP];

    // Arbitration: req[o][p] means input p's head wants output o
    logic [NP-1:0]     req      [NP];
    logic [NP-1:0]     loadable;
    logic [NP-1:0]     gnt_any;
    logic [1:0]        gnt_idx  [NP];
    logic [1:0]        rr_ptr   [NP];

    // FIFO status, head read-out and destination decode
    // NOTE: combinational blocks use blocking '=' and assign every output on every path, so no latches are inferred.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            fifo_empty[p] = (wr_ptr[p] == rd_ptr[p]);
            fifo_full[p]  = (wr_ptr[p][AW] != rd_ptr[p][AW]) &&
                            (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]);
            push[p]       = in_valid[p] && !fifo_full[p];
            head_dest[p]  = mem_dest[p][rd_ptr[p][AW-1:0]];
            head_data[p]  = mem_data[p][rd_ptr[p][AW-1:0]];
            head_inv[p]   = !fifo_empty[p] && (head_dest[p][5:2] == 4'd0);
            // Groups 1,5,9,13 -> 0; 2,6,10,14 -> 1; and so on.
            head_out[p]   = 2'(head_dest[p][5:2] - 4'd1);
        end
    end

    // A slot freed by a pop becomes visible only after the edge, so a full
    // FIFO never accepts in the same cycle it pops.
    assign in_ready = ~fifo_full;

    // Per-output request collection and round-robin grant
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            loadable[o] = !out_valid[o] || out_ready[o];
            req[o]      = '0;
            for (int p = 0; p < NP; p++) begin
                req[o][p] = !fifo_empty[p] && !head_inv[p] &&
                            (head_out[p] == 2'(o));
            end
            gnt_any[o] = 1'b0;
            gnt_idx[o] = rr_ptr[o];
            if (loadable[o]) begin
                // Search ptr+1 .. ptr+4; the last step wraps back to ptr itself.
                for (int k = 1; k <= NP; k++) begin
                    if (!gnt_any[o] && req[o][rr_ptr[o] + 2'(k)]) begin
                        gnt_any[o] = 1'b1;
                        gnt_idx[o] = rr_ptr[o] + 2'(k);
                    end
                end
            end
        end
    end

    // Pop on a grant or unconditionally for an invalid head. A head maps to
    // a single output, so at most one grant can name any given input.
    always_comb begin
        pop = head_inv;
        for (int o = 0; o < NP; o++) begin
            if (gnt_any[o]) begin
                pop[gnt_idx[o]] = 1'b1;
            end
        end
    end

    // FIFO pointer update
    // NOTE: sequential state is updated with non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
            end
        end
    end

    // FIFO storage write
    // NOTE: storage arrays have no reset; the pointer reset alone empties the FIFOs and stale contents are never read.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p]) begin
                mem_dest[p][wr_ptr[p][AW-1:0]] <= in_dest[6*p +: 6];
                mem_data[p][wr_ptr[p][AW-1:0]] <= in_data[DATA_W*p +: DATA_W];
            end
        end
    end

    // Output registers, round-robin pointers and drop reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_dest  <= '0;
            out_data  <= '0;
            drop_err  <= '0;
            for (int o = 0; o < NP; o++) begin
                rr_ptr[o] <= 2'd3;
            end
        end else begin
            drop_err <= head_inv;
            for (int o = 0; o < NP; o++) begin
                if (gnt_any[o]) begin
                    out_valid[o]                  <= 1'b1;
                    out_dest[6*o +: 6]            <= head_dest[gnt_idx[o]];
                    out_data[DATA_W*o +: DATA_W]  <= head_data[gnt_idx[o]];
                    rr_ptr[o]                     <= gnt_idx[o];
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spine_switch_fwd.sv
// Bench for spine_switch_fwd: directed stimulus pushes hand-computed expected
// flits into a scoreboard; a monitor pops and compares on every output handshake.
module tb_spine_switch_fwd;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      in_valid;
    logic [3:0]      in_ready;
    logic [23:0]     in_dest;
    logic [4*DW-1:0] in_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [23:0]     out_dest;
    logic [4*DW-1:0] out_data;
    logic [3:0]      drop_err;

    typedef struct {
        int          o;
        logic [5:0]  dest;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   drop_cnt[4];

    spine_switch_fwd #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dest  (out_dest),
        .out_data  (out_data),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_flit(input int o, input logic [5:0] d, input logic [31:0] x);
        exp_t e;
        e.o = o; e.dest = d; e.data = x;
        sb.push_back(e);
    endtask

    // Drive one cycle of input flits; every driven port is expected to be accepted.
    task automatic cycle_in(input logic [3:0] v, input logic [23:0] d,
                            input logic [4*DW-1:0] x, input string name);
        logic [3:0] acc;
        in_valid = v; in_dest = d; in_data = x;
        acc = v & in_ready;
        @(posedge clk);
        #1;
        check({name, "_acc"}, 64'(acc), 64'(v));
        in_valid = '0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_drain"}, 64'(sb.size()), 64'd0);
        check({name, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    // Monitor: compare every completed output handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int o = 0; o < 4; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (idx < 0 && sb[i].o == o) idx = i;
                    if (idx < 0) begin
                        total++;
                        bad++;
                        $display("FAIL out%0d_unexpected: got dest=%0h data=%0h, expected no flit",
                                 o, out_dest[6*o +: 6], out_data[32*o +: 32]);
                    end else begin
                        check($sformatf("out%0d_flit", o),
                              64'({out_dest[6*o +: 6], out_data[32*o +: 32]}),
                              64'({sb[idx].dest, sb[idx].data}));
                        sb.delete(idx);
                    end
                end
            end
            for (int p = 0; p < 4; p++)
                if (drop_err[p]) drop_cnt[p]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int hi_cnt;
        rst_n = 1'b0; in_valid = '0; in_dest = '0; in_data = '0; out_ready = 4'hF;
        for (int p = 0; p < 4; p++) drop_cnt[p] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'hF);
        check("rst_drop_err", 64'(drop_err), 64'd0);
        check("rst_out_dest", 64'(out_dest), 64'd0);
        check("rst_out_data_lo", out_data[63:0], 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-traffic: two flits parked toward out2, then reset.
        out_ready = 4'b1011;
        cycle_in(4'b0001, {18'b0, 6'b001101}, {96'b0, 32'h1111_1111}, "t1a");
        cycle_in(4'b0001, {18'b0, 6'b001101}, {96'b0, 32'h2222_2222}, "t1b");
        check("t1_pre_valid", 64'(out_valid), 64'h4);
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_out_valid", 64'(out_valid), 64'd0);
        check("t1_rst_in_ready", 64'(in_ready), 64'hF);
        check("t1_rst_drop_err", 64'(drop_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("t1_after_out_valid", 64'(out_valid), 64'd0);
        check("t1_after_in_ready", 64'(in_ready), 64'hF);

        // Single flit, group 3 -> out2, two-edge latency.
        expect_flit(2, 6'b001101, 32'hA5A5_A5A5);
        cycle_in(4'b0001, {18'b0, 6'b001101}, {96'b0, 32'hA5A5_A5A5}, "t2");
        check("t2_lat1", 64'(out_valid[2]), 64'd0);
        @(posedge clk); #1;
        check("t2_lat2", 64'(out_valid[2]), 64'd1);
        wait_drain("t2");

        // All inputs to group 4 (out3), three rounds; grants rotate 0,1,2,3.
        for (int r = 0; r < 3; r++) begin
            logic [4*DW-1:0] x;
            for (int p = 0; p < 4; p++) begin
                x[32*p +: 32] = 32'h3000_0000 | (r << 4) | p;
                expect_flit(3, 6'b010000, 32'h3000_0000 | (r << 4) | p);
            end
            cycle_in(4'hF, {4{6'b010000}}, x, $sformatf("t3_r%0d", r));
        end
        hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid[3]) hi_cnt++;
            @(posedge clk); #1;
        end
        check("t3_back_to_back", 64'(hi_cnt), 64'd10);
        wait_drain("t3");

        // Backpressure on out1: port1 sends 5 flits to group 2 (self-loop).
        out_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            expect_flit(1, 6'b001000, 32'h4000_0000 + i);
            cycle_in(4'b0010, {12'b0, 6'b001000, 6'b0},
                     {64'b0, 32'h4000_0000 + i, 32'b0}, $sformatf("t4_%0d", i));
        end
        check("t4_in_ready_full", 64'(in_ready[1]), 64'd0);
        check("t4_hold_valid", 64'(out_valid[1]), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_hold_data", 64'(out_data[63:32]), 64'h4000_0000);
        check("t4_still_full", 64'(in_ready[1]), 64'd0);
        out_ready = 4'hF;
        wait_drain("t4");
        check("t4_in_ready_back", 64'(in_ready), 64'hF);

        // GroupID 0 on port3: dropped with a single pulse, nothing forwarded.
        for (int p = 0; p < 4; p++) drop_cnt[p] = 0;
        cycle_in(4'b1000, {6'b000010, 18'b0}, {32'hDEAD_BEEF, 96'b0}, "t5");
        @(posedge clk); #1;
        check("t5_pulse", 64'(drop_err), 64'h8);
        check("t5_no_out", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("t5_pulse_end", 64'(drop_err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("t5_drop_cnt3", 64'(drop_cnt[3]), 64'd1);
        check("t5_drop_cnt_other", 64'(drop_cnt[0] + drop_cnt[1] + drop_cnt[2]), 64'd0);

        // Groups 1 and 5 from ports 0,1 in the same cycle -> out0, port0 first.
        expect_flit(0, 6'b000111, 32'h6000_0000);
        expect_flit(0, 6'b010100, 32'h6000_0001);
        cycle_in(4'b0011, {12'b0, 6'b010100, 6'b000111},
                 {64'b0, 32'h6000_0001, 32'h6000_0000}, "t6");
        @(posedge clk); #1;
        check("t6_first_out0", 64'(out_data[31:0]), 64'h6000_0000);
        @(posedge clk); #1;
        check("t6_second_out0", 64'(out_data[31:0]), 64'h6000_0001);
        wait_drain("t6");

        // Wrapping groups: 9 -> out0, 15 -> out2.
        expect_flit(0, 6'b100101, 32'h7000_0009);
        cycle_in(4'b0100, {6'b0, 6'b100101, 12'b0}, {32'b0, 32'h7000_0009, 64'b0}, "t7a");
        expect_flit(2, 6'b111110, 32'h7000_000F);
        cycle_in(4'b0100, {6'b0, 6'b111110, 12'b0}, {32'b0, 32'h7000_000F, 64'b0}, "t7b");
        wait_drain("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
